// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   idx_w()       : index width for a power-of-two depth (minimum 1)
//   MEM_LAT_MIN/MAX : legal range of the instruction-memory read latency
package mips_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 2;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch_entry_t, head shown combinationally.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO in one edge, wins over push
//   push, din  : enqueue din (caller guarantees room, or pop in the same cycle)
//   pop        : dequeue head (ignored when empty)
//   head       : current head entry (stale contents when empty)
//   count      : number of buffered entries
//   empty, full: occupancy flags
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  fetch_entry_t                   din,
  input  logic                           pop,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     store_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop_c;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head     = store_q[rd_ptr_q];
  assign do_pop_c = pop && !empty;

  // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop_c);
      assert (!(push && full && !do_pop_c));
    end
  end

  // Storage is not reset; only entries behind a valid count are ever observed.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) store_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC/commit registers, instruction memory with a
// 1- or 2-cycle read pipeline, credit-based issue and a prefetch FIFO.
//   clk, rst            : clock, synchronous active-high reset
//   clr                 : flush and replay from the next undelivered instruction
//   redirect_valid/_pc  : taken branch/jump, target word-aligned internally
//   instr_ready         : decode accepts the head instruction
//   instr_valid/instr/instr_pc : FIFO head (held at last value when empty)
//   pc_out              : next address to be requested from memory
//   fifo_count          : buffered entries
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       IMEM_DEPTH = 256,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       MEM_LAT    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              redirect_valid,
  input  logic [ADDR_W-1:0]                 redirect_pc,
  input  logic                              instr_ready,
  output logic                              instr_valid,
  output logic [DATA_W-1:0]                 instr,
  output logic [ADDR_W-1:0]                 instr_pc,
  output logic [ADDR_W-1:0]                 pc_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned LAT   = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                                  (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam int unsigned IDX_W = idx_w(IMEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH+LAT+1);

  logic [DATA_W-1:0] mem_array [IMEM_DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] commit_pc_q, commit_pc_d;
  logic [ADDR_W-1:0] redir_pc_c;
  logic [LAT-1:0]    pipe_vld_q;
  logic [ADDR_W-1:0] pipe_pc_q   [LAT];
  logic [DATA_W-1:0] pipe_data_q [LAT];
  logic              flush_c, deq_c, issue_c;
  logic [SUM_W-1:0]  in_flight_c, pending_c;
  fetch_entry_t      push_entry_c, head_c, last_q;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              unused_c;

  assign unused_c   = ^redirect_pc[1:0];
  assign redir_pc_c = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign flush_c    = redirect_valid || clr;
  assign deq_c      = !fifo_empty && instr_ready;

  // Reads in the latency pipe already own a FIFO slot; issue only if one is left.
  always_comb begin
    in_flight_c = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      in_flight_c = in_flight_c + SUM_W'(pipe_vld_q[i]);
    end
    pending_c = SUM_W'(fifo_cnt) + in_flight_c - SUM_W'(deq_c);
    issue_c   = !rst && !flush_c && (pending_c < SUM_W'(FIFO_DEPTH));
  end

  // Next PC: redirect beats clr; clr replays from the post-dequeue commit point.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    commit_pc_d = commit_pc_q;
    if (deq_c) commit_pc_d = instr_pc + ADDR_W'(4);
    if (redirect_valid) begin
      fetch_pc_d  = redir_pc_c;
      commit_pc_d = redir_pc_c;
    end else if (clr) begin
      fetch_pc_d = commit_pc_d;
    end else if (issue_c) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      commit_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      commit_pc_q <= commit_pc_d;
    end
  end

  // Valid bits of the read pipeline; a flush kills every read in flight.
  always_ff @(posedge clk) begin
    if (rst || flush_c) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= issue_c;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  // Memory read and its pc travel together; stage 0 is the synchronous read.
  always_ff @(posedge clk) begin
    pipe_pc_q[0]   <= fetch_pc_q;
    pipe_data_q[0] <= mem_array[fetch_pc_q[IDX_W+1:2]];
    for (int i = 1; i < int'(LAT); i++) begin
      pipe_pc_q[i]   <= pipe_pc_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  always_comb begin
    push_entry_c       = '0;
    push_entry_c.pc    = FETCH_ADDR_W'(pipe_pc_q[LAT-1]);
    push_entry_c.instr = FETCH_DATA_W'(pipe_data_q[LAT-1]);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_c),
    .push  (pipe_vld_q[LAT-1]),
    .din   (push_entry_c),
    .pop   (deq_c),
    .head  (head_c),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Credit accounting must never let a landing read hit a full, non-draining FIFO.
  always_ff @(posedge clk) begin
    if (!rst && !flush_c) assert (!(pipe_vld_q[LAT-1] && fifo_full && !deq_c));
  end

  // Last head seen, so the outputs hold while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst)              last_q <= '0;
    else if (!fifo_empty) last_q <= head_c;
  end

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? DATA_W'(last_q.instr) : DATA_W'(head_c.instr);
  assign instr_pc    = fifo_empty ? ADDR_W'(last_q.pc)    : ADDR_W'(head_c.pc);
  assign pc_out      = fetch_pc_q;
  assign fifo_count  = fifo_cnt;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: two instances (MEM_LAT=1 and MEM_LAT=2) share
// one stimulus stream and are both checked every cycle against a queue model.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst, clr, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;

  logic [1:0]       v;
  logic [1:0][31:0] ins;
  logic [1:0][31:0] ipc;
  logic [1:0][31:0] pco;
  logic [1:0][2:0]  cnt;

  int n_vec = 0;
  int n_err = 0;

  mips_fetch_unit #(.MEM_LAT(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_ready(instr_ready),
    .instr_valid(v[0]), .instr(ins[0]), .instr_pc(ipc[0]),
    .pc_out(pco[0]), .fifo_count(cnt[0]));

  mips_fetch_unit #(.MEM_LAT(2)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_ready(instr_ready),
    .instr_valid(v[1]), .instr(ins[1]), .instr_pc(ipc[1]),
    .pc_out(pco[1]), .fifo_count(cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of pcs, list of in-flight reads with remaining edges.
  bit [31:0] m_fetch  [2];
  bit [31:0] m_commit [2];
  bit [31:0] m_fq     [2][8];
  int        m_fn     [2];
  bit [31:0] m_ifpc   [2][4];
  int        m_ifage  [2][4];
  int        m_ifn    [2];
  bit [31:0] m_lastpc [2];
  bit [31:0] m_lasti  [2];

  function automatic bit [31:0] ref_instr(input bit [31:0] pc);
    return 32'h100 + ((pc >> 2) & 32'hFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int k, input bit r, input bit c, input bit rd,
                            input bit [31:0] rpc, input bit rdy);
    int  lat;
    bit  deq, issue;
    lat = k + 1;
    if (r) begin
      m_fetch[k] = 0; m_commit[k] = 0; m_fn[k] = 0; m_ifn[k] = 0;
      m_lastpc[k] = 0; m_lasti[k] = 0;
    end else begin
      deq = (m_fn[k] > 0) && rdy;
      if (m_fn[k] > 0) begin
        m_lastpc[k] = m_fq[k][0];
        m_lasti[k]  = ref_instr(m_fq[k][0]);
      end
      issue = !(rd || c) && (m_fn[k] + m_ifn[k] - int'(deq) < 4);
      if (deq) begin
        m_commit[k] = m_fq[k][0] + 4;
        for (int i = 0; i < 7; i++) m_fq[k][i] = m_fq[k][i+1];
        m_fn[k]--;
      end
      if (rd || c) begin
        if (rd) begin
          m_fetch[k]  = rpc & 32'hFFFF_FFFC;
          m_commit[k] = m_fetch[k];
        end else begin
          m_fetch[k] = m_commit[k];
        end
        m_fn[k]  = 0;
        m_ifn[k] = 0;
      end else begin
        for (int i = 0; i < m_ifn[k]; i++) m_ifage[k][i]--;
        while (m_ifn[k] > 0 && m_ifage[k][0] == 0) begin
          m_fq[k][m_fn[k]] = m_ifpc[k][0];
          m_fn[k]++;
          for (int i = 0; i < 3; i++) begin
            m_ifpc[k][i]  = m_ifpc[k][i+1];
            m_ifage[k][i] = m_ifage[k][i+1];
          end
          m_ifn[k]--;
        end
        if (issue) begin
          m_ifpc[k][m_ifn[k]]  = m_fetch[k];
          m_ifage[k][m_ifn[k]] = lat;
          m_ifn[k]++;
          m_fetch[k] = m_fetch[k] + 4;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit rd, input bit [31:0] rpc,
                      input bit rdy);
    bit [31:0] epc, eins;
    rst = r; clr = c; redirect_valid = rd; redirect_pc = rpc; instr_ready = rdy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, r, c, rd, rpc, rdy);
    #1;
    for (int k = 0; k < 2; k++) begin
      epc  = (m_fn[k] > 0) ? m_fq[k][0] : m_lastpc[k];
      eins = (m_fn[k] > 0) ? ref_instr(m_fq[k][0]) : m_lasti[k];
      check($sformatf("u%0d.instr_valid", k), 32'(v[k]), 32'(m_fn[k] > 0));
      check($sformatf("u%0d.instr_pc", k), ipc[k], epc);
      check($sformatf("u%0d.instr", k), ins[k], eins);
      check($sformatf("u%0d.pc_out", k), pco[k], m_fetch[k]);
      check($sformatf("u%0d.fifo_count", k), 32'(cnt[k]), 32'(m_fn[k]));
    end
  endtask

  // After a flush/reset edge: valid must rise exactly MEM_LAT+1 edges later at the given pc.
  task automatic expect_first(input bit [31:0] exp0, input bit [31:0] exp1, input string tag);
    bit        seen [2];
    bit [31:0] exp  [2];
    exp[0] = exp0; exp[1] = exp1;
    seen[0] = 1'b0; seen[1] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step(0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        if (!seen[k] && v[k]) begin
          seen[k] = 1'b1;
          check($sformatf("%s.u%0d.latency", tag, k), 32'(n), 32'(k + 2));
          check($sformatf("%s.u%0d.first_pc", tag, k), ipc[k], exp[k]);
          check($sformatf("%s.u%0d.first_instr", tag, k), ins[k], ref_instr(exp[k]));
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (!seen[k]) check($sformatf("%s.u%0d.timeout", tag, k), 32'(v[k]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      u0.mem_array[i] = 32'(i + 32'h100);
      u1.mem_array[i] = 32'(i + 32'h100);
    end

    // Reset, fill latency and streaming.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    expect_first(32'h0, 32'h0, "reset");
    repeat (10) step(0, 0, 0, 0, 1);

    // Stall from reset: FIFO saturates and fetch stops four words ahead.
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall.u%0d.pc_out", k), pco[k], 32'h10);
      check($sformatf("stall.u%0d.count", k), 32'(cnt[k]), 32'd4);
    end
    repeat (12) step(0, 0, 0, 0, 1);

    // Redirect with unaligned target.
    step(0, 0, 1, 32'h43, 1);
    expect_first(32'h40, 32'h40, "redirect");
    repeat (6) step(0, 0, 0, 0, 1);

    // Clear replays from the first undelivered instruction.
    step(1, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    expect_first(32'h8, 32'h4, "clr");
    repeat (6) step(0, 0, 0, 0, 1);

    // Redirect wins over a simultaneous clear.
    step(0, 1, 1, 32'h80, 1);
    expect_first(32'h80, 32'h80, "clr_redir");

    // Back-to-back redirects: only the last target is fetched.
    step(0, 0, 1, 32'h200, 1);
    step(0, 0, 1, 32'h300, 1);
    expect_first(32'h300, 32'h300, "double_redir");

    // Redirect while stalled with a full FIFO.
    repeat (10) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h500, 0);
    expect_first(32'h500, 32'h500, "stall_redir");

    // Memory index wrap past the last word.
    step(0, 0, 1, 32'h3FC, 1);
    expect_first(32'h3FC, 32'h3FC, "wrap");
    repeat (4) step(0, 0, 0, 0, 1);

    // Randomised traffic, including targets near the top of the address space.
    for (int i = 0; i < 400; i++) begin
      bit        r, c, rd, rdy;
      bit [31:0] rpc;
      r   = ($urandom_range(99) == 0);
      rd  = ($urandom_range(19) == 0);
      c   = ($urandom_range(19) == 0);
      rdy = ($urandom_range(3) != 0);
      rpc = $urandom;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      step(r, c, rd, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the MIPS core. It replaces the fixed PC register plus single-cycle instruction memory read.
- Owns the PC, an internal instruction memory with configurable read latency, and a prefetch buffer.
- Delivers instructions to decode over a valid/ready handshake.
- Supports branch/jump redirect and a replaying clear.

Parameters:
- ADDR_W, 32, PC/byte-address width.
- DATA_W, 32, instruction width.
- IMEM_DEPTH, 256, instruction words in memory (power of 2).
- FIFO_DEPTH, 4, prefetch buffer entries (power of 2, ≥2).
- MEM_LAT, 1, memory read latency in cycles (1 or 2).
- RESET_PC, 0, PC after reset (word aligned).

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- clr, in, 1, synchronous flush with replay from the next undelivered instruction.
- redirect_valid, in, 1, branch/jump taken this cycle.
- redirect_pc, in, ADDR_W, redirect target; bits [1:0] ignored and forced 0.
- instr_ready, in, 1, decode accepts head instruction.
- instr_valid, out, 1, head instruction valid.
- instr, out, DATA_W, head instruction word.
- instr_pc, out, ADDR_W, byte address of instr.
- pc_out, out, ADDR_W, next address to be requested from memory (fetch_pc).
- fifo_count, out, $clog2(FIFO_DEPTH+1), buffered entries.

Behaviour:
- Reset: fetch_pc=RESET_PC; commit_pc=RESET_PC; FIFO empty; in-flight reads killed.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, fifo_count=0, pc_out=RESET_PC.
  - Memory contents are not reset. Array is named mem_array so the bench can preload it hierarchically.
- Memory index is fetch_pc[$clog2(IMEM_DEPTH)+1:2]. Addresses beyond depth wrap modulo IMEM_DEPTH.
- Issue: one read per cycle when (fifo_count + in_flight) < FIFO_DEPTH after this cycle's dequeue.
  - On issue, fetch_pc <= fetch_pc+4 (wraps at 2^ADDR_W).
  - Read data and its pc enter the FIFO exactly MEM_LAT edges after issue.
  - Credit accounting guarantees the FIFO never overflows; overflow is an assertion failure.
- Output: instr/instr_pc come combinationally from the FIFO head, with no bypass.
  - When empty, instr_valid=0, and instr/instr_pc hold their last values (0 after reset).
  - Dequeue occurs when instr_valid && instr_ready. On dequeue, commit_pc <= instr_pc+4.
- Steady state: with instr_ready=1 and no redirect, one instruction is delivered per cycle after fill.
  - First instr_valid appears MEM_LAT+1 cycles after rst deasserts.
- Redirect, when redirect_valid is sampled at edge t:
  - A dequeue at edge t is still honored.
  - The FIFO is emptied and all in-flight reads are killed; their data is dropped.
  - fetch_pc <= redirect_pc; commit_pc <= redirect_pc.
  - The read of redirect_pc issues in cycle t+1. instr_valid rises MEM_LAT+1 cycles after edge t and is 0 in between.
- Clear, when clr is sampled:
  - Same flush as redirect, but fetch_pc <= commit_pc (post-dequeue value).
  - Instructions not yet delivered are re-fetched in order. No instruction is lost or duplicated.
- Priority: rst > redirect_valid > clr.
  - Repeated redirects on consecutive cycles: only the last target is fetched.
- A redirect or clr during a stall (instr_ready=0, FIFO full) still flushes immediately.
- A read issued in the same cycle as a redirect/clr is killed.

Decomposition:
- Package mips_fetch_pkg holds:
  - the fetch_entry_t struct {pc, instr};
  - an index-width helper function;
  - the MEM_LAT legal-range constant.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; ports clk, rst, flush, push, pop, head, count, empty, full.
  - Simultaneous push+pop is allowed when full (count unchanged).
  - flush empties it in one edge and has priority over push.
- The top level holds the PC/commit registers, memory, latency valid pipeline and credit logic.

Test Plan:
- Preload mem_array[i]=i+0x100. Release rst with instr_ready=1 and MEM_LAT=1 → instr_valid rises 2 cycles later. Sequence instr=0x100,0x101,0x102… with instr_pc=0,4,8…, one per cycle.
- Hold instr_ready=0 for 10 cycles → fifo_count saturates at 4 and pc_out stops at 0x10. Release → 0x100..0x103 delivered in order, then streaming resumes with no gap beyond MEM_LAT.
- After streaming, pulse redirect_valid with redirect_pc=0x43 → target treated as 0x40. instr_valid is low for 2 cycles, then instr=0x110, instr_pc=0x40. No stale entries appear.
- Deliver instr_pc=0x0 and 0x4, hold instr_ready=0, then pulse clr → next delivered instr_pc=0x8 (0x102), then 0xC. No duplicates or skips.
- Pulse clr and redirect_valid (target 0x80) together → first delivered instr_pc=0x80.
- Set MEM_LAT=2 and redirect_pc=0x3FC with IMEM_DEPTH=256 → instr_valid 3 cycles after the edge. Sequence 0x3FC (mem[255]), then 0x400 wraps to mem[0]=0x100.
